// File: rtl/fifo_rr_sched_if.sv
// Producer and consumer stream signals of fifo_rr_sched bundled as one interface.
// The slave modport is the scheduler's view; the master modport is the
// view of whatever drives the producers and consumes the output stream.
interface fifo_rr_sched_if #(
    parameter int WORD_WDT = 64,
    parameter int N_REQ    = 4
);
    logic [N_REQ-1:0]          req_valid;
    logic [N_REQ-1:0]          req_last;
    logic [N_REQ*WORD_WDT-1:0] req_word;
    logic [N_REQ-1:0]          req_ready;
    logic                      out_valid;
    logic                      out_ready;
    logic [WORD_WDT-1:0]       out_word;

    modport master (
        output req_valid, req_last, req_word, out_ready,
        input  req_ready, out_valid, out_word
    );

    modport slave (
        input  req_valid, req_last, req_word, out_ready,
        output req_ready, out_valid, out_word
    );
endinterface

// File: rtl/fifo_rr_sched.sv
// fifo_rr_sched: round-robin, packet-locking write scheduler in front of a
// single-clock FIFO, with a one-word output stage that turns the FIFO's
// registered read port into a valid/ready stream.

// Single-clock FIFO with registered read data and registered full/empty flags.
module fifo_rr_sched_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [W-1:0]               wr_data,
    input  logic                       rd_en,
    output logic [W-1:0]               rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  rd_data_q, rd_data_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          do_wr, do_rd;

    // Next pointers, occupancy and flags; the flags are derived from the next level.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
        do_wr     = wr_en & ~full_q;
        do_rd     = rd_en & ~empty_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        rd_data_d = rd_data_q;
        level_d   = level_q;
        if (do_wr) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_rd) begin
            rd_ptr_d  = rd_ptr_q + AW'(1);
            rd_data_d = mem_q[rd_ptr_q];
        end
        if (do_wr && !do_rd) begin
            level_d = level_q + LW'(1);
        end else if (!do_wr && do_rd) begin
            level_d = level_q - LW'(1);
        end
        full_d  = (level_d == LW'(DEPTH));
        empty_d = (level_d == '0);
    end

    // Control registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage array and read-data register.
    always_ff @(posedge clk) begin
        // NOTE: the array and read register are not reset; contents are only observed after a write or read qualifies them.
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
        rd_data_q <= rd_data_d;
    end

    assign rd_data = rd_data_q;
    assign full    = full_q;
    assign empty   = empty_q;
    assign level   = level_q;
endmodule

// Top: round-robin packet arbiter, FIFO instance and output stream stage.
module fifo_rr_sched #(
    parameter int WORD_WDT   = 64,
    parameter int FIFO_DEPTH = 8,
    parameter int N_REQ      = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    fifo_rr_sched_if.slave                bus,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          busy
);
    localparam int PTR_W = $clog2(N_REQ);
    localparam int SUM_W = PTR_W + 1;

    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } arb_state_e;

    arb_state_e          state_q, state_d;
    logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]    lock_id_q, lock_id_d;
    logic                out_valid_q, out_valid_d;

    logic                grant_vld;
    logic [PTR_W-1:0]    grant_id;
    logic [SUM_W-1:0]    scan_sum;
    logic [PTR_W-1:0]    scan_idx;
    logic [SUM_W-1:0]    nxt_sum;
    logic [WORD_WDT-1:0] in_word;
    logic                fifo_wr, fifo_rd;
    logic                fifo_full, fifo_empty;
    logic [WORD_WDT-1:0] fifo_rd_data;
    logic                fifo_rst_n;

    // Arbitration: pick the grant, drive req_ready / write word, compute next lock state.
    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        lock_id_d     = lock_id_q;
        grant_vld     = 1'b0;
        grant_id      = '0;
        scan_sum      = '0;
        scan_idx      = '0;
        nxt_sum       = '0;
        in_word       = '0;
        bus.req_ready = '0;

        case (state_q)
            ST_UNLOCKED: begin
                if (!fifo_full) begin
                    // Search rr_ptr, rr_ptr+1, ... modulo N_REQ; first valid wins.
                    for (int k = 0; k < N_REQ; k++) begin
                        scan_sum = {1'b0, rr_ptr_q} + SUM_W'(k);
                        if (scan_sum >= SUM_W'(N_REQ)) begin
                            scan_sum = scan_sum - SUM_W'(N_REQ);
                        end
                        scan_idx = scan_sum[PTR_W-1:0];
                        if (!grant_vld && bus.req_valid[scan_idx]) begin
                            grant_vld = 1'b1;
                            grant_id  = scan_idx;
                        end
                    end
                end
            end
            ST_LOCKED: begin
                // Only the lock owner may write; a valid gap simply holds the lock.
                if (!fifo_full && bus.req_valid[lock_id_q]) begin
                    grant_vld = 1'b1;
                    grant_id  = lock_id_q;
                end
            end
            default: begin
                state_d = ST_UNLOCKED;
            end
        endcase

        if (rst) begin
            grant_vld = 1'b0;
        end

        for (int i = 0; i < N_REQ; i++) begin
            if (grant_vld && grant_id == PTR_W'(i)) begin
                bus.req_ready[i] = 1'b1;
                in_word          = bus.req_word[i*WORD_WDT +: WORD_WDT];
            end
        end

        // The last beat releases the lock and moves priority past the granted producer.
        nxt_sum = {1'b0, grant_id} + SUM_W'(1);
        if (nxt_sum == SUM_W'(N_REQ)) begin
            nxt_sum = '0;
        end
        if (grant_vld) begin
            if (bus.req_last[grant_id]) begin
                state_d  = ST_UNLOCKED;
                rr_ptr_d = nxt_sum[PTR_W-1:0];
            end else begin
                state_d   = ST_LOCKED;
                lock_id_d = grant_id;
            end
        end
    end

    assign fifo_wr = grant_vld;

    // Read side: pull from the FIFO whenever the output stage is empty or being drained.
    always_comb begin
        fifo_rd     = !rst && !fifo_empty && (!out_valid_q || bus.out_ready);
        out_valid_d = fifo_rd || (out_valid_q && !bus.out_ready);
    end

    // Arbiter and output-stage registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_UNLOCKED;
            rr_ptr_q    <= '0;
            lock_id_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            lock_id_q   <= lock_id_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign fifo_rst_n = !rst;

    fifo_rr_sched_fifo #(
        .W     (WORD_WDT),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (fifo_rst_n),
        .wr_en   (fifo_wr),
        .wr_data (in_word),
        .rd_en   (fifo_rd),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    // The FIFO read register is the output word; it holds because no read occurs while stalled.
    assign bus.out_valid = out_valid_q;
    assign bus.out_word  = fifo_rd_data;
    assign busy          = out_valid_q | (fifo_level != '0) | (state_q == ST_LOCKED);
endmodule
